// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding select codes
// and default multiply/divide busy latencies.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_M    = 2'd1;
  localparam logic [1:0] FWD_W    = 2'd2;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide busy counter: loads the unit latency when an md op leaves E,
// then counts down to zero; md_busy is high while the count is nonzero.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             md_start,
  input  logic             md_div,
  output logic [CNT_W-1:0] busy_cnt,
  output logic             md_busy
);

  always_ff @(posedge clk) begin
    if (rst)
      busy_cnt <= '0;
    else if (md_start)
      busy_cnt <= md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    else if (busy_cnt != '0)
      busy_cnt <= busy_cnt - 1'b1;
  end

  assign md_busy = (busy_cnt != '0);

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: stall/flush generation and D/E-stage
// forwarding selects. Define HAZARD_STAT_EN to add the saturating stall_cnt port.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic       rs_rd_D,
  input  logic       rt_rd_D,
  input  logic       branch_D,
  input  logic       md_use_D,
  input  logic [4:0] rs_E,
  input  logic [4:0] rt_E,
  input  logic [4:0] wa_E,
  input  logic [4:0] wa_M,
  input  logic [4:0] wa_W,
  input  logic       RegWrite_E,
  input  logic       RegWrite_M,
  input  logic       RegWrite_W,
  input  logic       MemToReg_E,
  input  logic       MemToReg_M,
  input  logic       md_start_E,
  input  logic       md_div_E,
  output logic       stall_F,
  output logic       stall_D,
  output logic       flush_E,
  output logic [1:0] fwd_rs_D,
  output logic [1:0] fwd_rt_D,
  output logic [1:0] fwd_rs_E,
  output logic [1:0] fwd_rt_E,
  output logic       md_busy
`ifdef HAZARD_STAT_EN
  ,output logic [31:0] stall_cnt
`endif
);

  logic [CNT_W-1:0] busy_cnt;
  logic             cnt_busy;

  md_busy_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_cnt (
    .clk      (clk),
    .rst      (rst),
    .md_start (md_start_E),
    .md_div   (md_div_E),
    .busy_cnt (busy_cnt),
    .md_busy  (cnt_busy)
  );

  // $0 is hardwired zero, so it never produces a hazard or a forward.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] wa,
                                     input logic we);
    return we && (src != 5'd0) && (src == wa);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
    if (m_hit)      return FWD_M;
    else if (w_hit) return FWD_W;
    else            return FWD_NONE;
  endfunction

  logic rs_hit_E, rt_hit_E, rs_hit_M, rt_hit_M;
  logic load_use, br_E, br_M, md_stall, stall;

  always_comb begin
    rs_hit_E = rs_rd_D && reg_match(rs_D, wa_E, RegWrite_E);
    rt_hit_E = rt_rd_D && reg_match(rt_D, wa_E, RegWrite_E);
    rs_hit_M = rs_rd_D && reg_match(rs_D, wa_M, RegWrite_M);
    rt_hit_M = rt_rd_D && reg_match(rt_D, wa_M, RegWrite_M);

    load_use = MemToReg_E && (rs_hit_E || rt_hit_E);
    br_E     = branch_D && (rs_hit_E || rt_hit_E);
    br_M     = branch_D && MemToReg_M && (rs_hit_M || rt_hit_M);
    md_stall = md_use_D && (cnt_busy || md_start_E);
    stall    = !rst && (load_use || br_E || br_M || md_stall);
  end

  assign stall_F = stall;
  assign stall_D = stall;
  assign flush_E = stall;
  assign md_busy = !rst && cnt_busy;

  // A load in M is excluded from D forwarding; its data is not ready until W.
  always_comb begin
    fwd_rs_D = FWD_NONE;
    fwd_rt_D = FWD_NONE;
    fwd_rs_E = FWD_NONE;
    fwd_rt_E = FWD_NONE;
    if (!rst) begin
      fwd_rs_D = fwd_sel(!MemToReg_M && reg_match(rs_D, wa_M, RegWrite_M),
                         reg_match(rs_D, wa_W, RegWrite_W));
      fwd_rt_D = fwd_sel(!MemToReg_M && reg_match(rt_D, wa_M, RegWrite_M),
                         reg_match(rt_D, wa_W, RegWrite_W));
      fwd_rs_E = fwd_sel(reg_match(rs_E, wa_M, RegWrite_M),
                         reg_match(rs_E, wa_W, RegWrite_W));
      fwd_rt_E = fwd_sel(reg_match(rt_E, wa_M, RegWrite_M),
                         reg_match(rt_E, wa_W, RegWrite_W));
    end
  end

`ifdef HAZARD_STAT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit: reset, load-use, branch,
// forwarding priority, divide busy window and reset during a multiply.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, wa_E, wa_M, wa_W;
  logic       rs_rd_D, rt_rd_D, branch_D, md_use_D;
  logic       RegWrite_E, RegWrite_M, RegWrite_W, MemToReg_E, MemToReg_M;
  logic       md_start_E, md_div_E;
  logic       stall_F, stall_D, flush_E, md_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E;
`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk        (clk),
    .rst        (rst),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .rs_rd_D    (rs_rd_D),
    .rt_rd_D    (rt_rd_D),
    .branch_D   (branch_D),
    .md_use_D   (md_use_D),
    .rs_E       (rs_E),
    .rt_E       (rt_E),
    .wa_E       (wa_E),
    .wa_M       (wa_M),
    .wa_W       (wa_W),
    .RegWrite_E (RegWrite_E),
    .RegWrite_M (RegWrite_M),
    .RegWrite_W (RegWrite_W),
    .MemToReg_E (MemToReg_E),
    .MemToReg_M (MemToReg_M),
    .md_start_E (md_start_E),
    .md_div_E   (md_div_E),
    .stall_F    (stall_F),
    .stall_D    (stall_D),
    .flush_E    (flush_E),
    .fwd_rs_D   (fwd_rs_D),
    .fwd_rt_D   (fwd_rt_D),
    .fwd_rs_E   (fwd_rs_E),
    .fwd_rt_E   (fwd_rt_E),
    .md_busy    (md_busy)
`ifdef HAZARD_STAT_EN
    ,.stall_cnt (stall_cnt)
`endif
  );

  task automatic clear_inputs();
    rs_D = 0; rt_D = 0; rs_E = 0; rt_E = 0; wa_E = 0; wa_M = 0; wa_W = 0;
    rs_rd_D = 0; rt_rd_D = 0; branch_D = 0; md_use_D = 0;
    RegWrite_E = 0; RegWrite_M = 0; RegWrite_W = 0;
    MemToReg_E = 0; MemToReg_M = 0; md_start_E = 0; md_div_E = 0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    MemToReg_E = 1; RegWrite_E = 1; wa_E = 8; rs_D = 8; rs_rd_D = 1;
    md_use_D = 1; md_start_E = 1;
    RegWrite_M = 1; wa_M = 5; rs_E = 5; rt_E = 5;
    #1;
    tests++;
    if ({stall_F, stall_D, flush_E} !== 3'b000) begin
      failed++; $display("FAIL reset_stall got=%b want=000", {stall_F, stall_D, flush_E});
    end
    tests++;
    if ({fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E} !== 8'h00) begin
      failed++; $display("FAIL reset_fwd got=%h want=00", {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E});
    end
    step();
    tests++;
    if (md_busy !== 1'b0) begin
      failed++; $display("FAIL reset_md_busy got=%b want=0", md_busy);
    end
    clear_inputs();
    rst = 1'b0;
    step();
    tests++;
    if (md_busy !== 1'b0) begin
      failed++; $display("FAIL post_reset_md_busy got=%b want=0", md_busy);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    MemToReg_E = 1; RegWrite_E = 1; wa_E = 8; rs_D = 8; rs_rd_D = 1;
    #1;
    tests++;
    if ({stall_F, stall_D, flush_E} !== 3'b111) begin
      failed++; $display("FAIL load_use_rs got=%b want=111", {stall_F, stall_D, flush_E});
    end
    rs_rd_D = 0;
    #1;
    tests++;
    if (stall_F !== 1'b0) begin
      failed++; $display("FAIL load_use_noread got=%b want=0", stall_F);
    end
    rs_D = 0; rt_D = 8; rt_rd_D = 1;
    #1;
    tests++;
    if ({stall_F, stall_D, flush_E} !== 3'b111) begin
      failed++; $display("FAIL load_use_rt got=%b want=111", {stall_F, stall_D, flush_E});
    end
    wa_E = 0; rt_D = 0;
    #1;
    tests++;
    if ({stall_F, stall_D, flush_E} !== 3'b000) begin
      failed++; $display("FAIL load_use_r0 got=%b want=000", {stall_F, stall_D, flush_E});
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    branch_D = 1; rt_D = 9; rt_rd_D = 1; RegWrite_E = 1; wa_E = 9;
    #1;
    tests++;
    if ({stall_F, stall_D, flush_E} !== 3'b111) begin
      failed++; $display("FAIL branch_E got=%b want=111", {stall_F, stall_D, flush_E});
    end
    step();
    RegWrite_E = 0; wa_E = 0; RegWrite_M = 1; wa_M = 9;
    #1;
    tests++;
    if (stall_D !== 1'b0 || fwd_rt_D !== 2'd1) begin
      failed++; $display("FAIL branch_M_fwd got stall=%b fwd=%0d want stall=0 fwd=1", stall_D, fwd_rt_D);
    end
    MemToReg_M = 1;
    #1;
    tests++;
    if (stall_D !== 1'b1 || fwd_rt_D !== 2'd0) begin
      failed++; $display("FAIL branch_M_load got stall=%b fwd=%0d want stall=1 fwd=0", stall_D, fwd_rt_D);
    end
    MemToReg_M = 0; RegWrite_M = 0; RegWrite_W = 1; wa_W = 9; rs_D = 9;
    #1;
    tests++;
    if (stall_D !== 1'b0 || fwd_rt_D !== 2'd2 || fwd_rs_D !== 2'd2) begin
      failed++; $display("FAIL branch_W_fwd got stall=%b rt=%0d rs=%0d want 0 2 2", stall_D, fwd_rt_D, fwd_rs_D);
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    rs_E = 5; rt_E = 5; wa_M = 5; wa_W = 5; RegWrite_M = 1; RegWrite_W = 1;
    #1;
    tests++;
    if (fwd_rs_E !== 2'd1 || fwd_rt_E !== 2'd1) begin
      failed++; $display("FAIL fwd_M_prio got rs=%0d rt=%0d want 1 1", fwd_rs_E, fwd_rt_E);
    end
    RegWrite_M = 0;
    #1;
    tests++;
    if (fwd_rs_E !== 2'd2) begin
      failed++; $display("FAIL fwd_W got=%0d want=2", fwd_rs_E);
    end
    rs_E = 0; wa_W = 0;
    #1;
    tests++;
    if (fwd_rs_E !== 2'd0) begin
      failed++; $display("FAIL fwd_r0 got=%0d want=0", fwd_rs_E);
    end
  endtask

  task automatic test_divide();
    int stall_cycles = 0;
    int busy_cycles  = 0;
    clear_inputs();
    md_use_D = 1; md_start_E = 1; md_div_E = 1;
    #1;
    tests++;
    if (stall_F !== 1'b1 || md_busy !== 1'b0) begin
      failed++; $display("FAIL div_start got stall=%b busy=%b want 1 0", stall_F, md_busy);
    end
    for (int i = 0; i < 20; i++) begin
      if (stall_F) stall_cycles++;
      if (md_busy) busy_cycles++;
      step();
      md_start_E = 0; md_div_E = 0;
      #1;
    end
    tests++;
    if (stall_cycles != 11) begin
      failed++; $display("FAIL div_stall_len got=%0d want=11", stall_cycles);
    end
    tests++;
    if (busy_cycles != 10) begin
      failed++; $display("FAIL div_busy_len got=%0d want=10", busy_cycles);
    end
    tests++;
    if (stall_F !== 1'b0 || md_busy !== 1'b0) begin
      failed++; $display("FAIL div_release got stall=%b busy=%b want 0 0", stall_F, md_busy);
    end
  endtask

  task automatic test_mult_reset();
    clear_inputs();
    md_start_E = 1;
    step();
    md_start_E = 0;
    step();
    step();
    md_use_D = 1;
    #1;
    tests++;
    if (md_busy !== 1'b1 || stall_F !== 1'b1) begin
      failed++; $display("FAIL mult_busy got busy=%b stall=%b want 1 1", md_busy, stall_F);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    tests++;
    if (md_busy !== 1'b0 || stall_F !== 1'b0) begin
      failed++; $display("FAIL mult_reset got busy=%b stall=%b want 0 0", md_busy, stall_F);
    end
    clear_inputs();
  endtask

  task automatic test_mult_len();
    int busy_cycles = 0;
    clear_inputs();
    md_start_E = 1;
    step();
    md_start_E = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (md_busy) busy_cycles++;
      step();
    end
    tests++;
    if (busy_cycles != 5) begin
      failed++; $display("FAIL mult_busy_len got=%0d want=5", busy_cycles);
    end
  endtask

`ifdef HAZARD_STAT_EN
  task automatic test_stall_cnt();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    MemToReg_E = 1; RegWrite_E = 1; wa_E = 3; rs_D = 3; rs_rd_D = 1;
    for (int i = 0; i < 7; i++) step();
    clear_inputs();
    step();
    tests++;
    if (stall_cnt !== 32'd7) begin
      failed++; $display("FAIL stall_cnt got=%0d want=7", stall_cnt);
    end
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_branch();
    test_forward();
    test_divide();
    test_mult_len();
    test_mult_reset();
`ifdef HAZARD_STAT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage core.
- Drives stall_F/stall_D into the F and D pipeline registers and flush_E into the D/E register, which treats flush exactly like its synchronous reset.
- Generates forwarding selects for the D-stage branch comparator and the E-stage ALU operands.
- Contains the multi-cycle multiply/divide busy counter that gates md-dependent instructions.

Parameters:
- MULT_LAT, 5, busy cycles after a mult/multu leaves E.
- DIV_LAT, 10, busy cycles after a div/divu leaves E.
- CNT_W, 4, busy counter width; must hold DIV_LAT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- rs_D, rt_D  in  5 each  D-stage source register numbers.
- rs_rd_D, rt_rd_D  in  1 each  D instruction reads rs/rt.
- branch_D  in  1  D instruction consumes rs/rt in D (beq/bne/jr).
- md_use_D  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- rs_E, rt_E  in  5 each  E-stage source register numbers.
- wa_E, wa_M, wa_W  in  5 each  destination register per stage.
- RegWrite_E, RegWrite_M, RegWrite_W  in  1 each  stage writes the register file.
- MemToReg_E, MemToReg_M  in  1 each  stage holds a load.
- md_start_E  in  1  E holds mult/multu/div/divu.
- md_div_E  in  1  that instruction is a divide.
- stall_F, stall_D  out  1 each  hold the F and D registers.
- flush_E  out  1  bubble into the D/E register.
- fwd_rs_D, fwd_rt_D  out  2 each  D comparator operand select.
- fwd_rs_E, fwd_rt_E  out  2 each  ALU operand select.
- md_busy  out  1  busy counter nonzero.

Behaviour:
- The only state is busy_cnt[CNT_W-1:0]. All other outputs are combinational from the inputs and busy_cnt.
- Reset:
  - busy_cnt is 0 on any clock edge with rst=1, including mid-operation.
  - While rst=1: stall_F=stall_D=flush_E=0, all fwd selects 0, md_busy=0.
- Counter update, per edge, first match wins:
  1. rst: 0.
  2. md_start_E: load DIV_LAT if md_div_E, else MULT_LAT. A start with busy_cnt≠0 reloads; this cannot occur legally because of the md stall.
  3. busy_cnt≠0: decrement.
  4. Otherwise: hold.
- md_busy = (busy_cnt≠0).
- A register match requires a nonzero register number plus the stage RegWrite. $0 never matches, never stalls, never forwards.
- Stall sources:
  - load_use: MemToReg_E, and wa_E matches rs_D (rs_rd_D) or rt_D (rt_rd_D).
  - br_E: branch_D, and wa_E matches a read source.
  - br_M: branch_D, MemToReg_M, and wa_M matches a read source.
  - md: md_use_D and (md_busy or md_start_E).
- stall = OR of all four sources; stall_F = stall_D = flush_E = stall.
- With no stall, flush_E=0 and the D/E register loads normally.
- Select encoding: 0 = register file/pipe value, 1 = M-stage ALU result, 2 = W-stage write data.
- D selects:
  - 1 if a non-load M matches.
  - Else 2 if W matches.
  - Else 0.
- E selects:
  - 1 if M matches, M priority.
  - Else 2 if W matches.
  - Else 0.
- A load in M selected via 1 is never consumed, since load_use stalled it earlier.
- Latency: stall is same-cycle; the bubble appears in E at the next edge. The counter reaches 0 exactly LAT edges after loading.

Optional Feature:
- Macro: HAZARD_STAT_EN.
- Defined:
  - Adds output port stall_cnt, 32 bits.
  - Reset 0; +1 on every non-reset cycle with stall=1; saturates at 32'hFFFF_FFFF.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package hazard_pkg:
  - forward select constants FWD_NONE=2'd0, FWD_M=2'd1, FWD_W=2'd2;
  - default MULT_LAT and DIV_LAT.
- One natural sub-module: md_busy_counter, holding busy_cnt, load/decrement and md_busy.
- Stall and forward logic stay in the top module.

Test Plan:
- Load-use: MemToReg_E=1, RegWrite_E=1, wa_E=8, rs_D=8, rs_rd_D=1 -> stall_F=stall_D=flush_E=1 same cycle; wa_E=0 -> all 0.
- Branch hazard:
  - branch_D=1, rt_D=9, RegWrite_E=1, wa_E=9 -> stall.
  - Next cycle the producer is in M as non-load -> no stall, fwd_rt_D=1.
- Forward priority: rs_E=5, wa_M=5, wa_W=5, both RegWrite=1 -> fwd_rs_E=1; RegWrite_M=0 -> 2; rs_E=0 -> 0.
- Divide:
  - md_start_E=1, md_div_E=1 at edge -> busy_cnt=10, md_busy=1 for 10 cycles.
  - md_use_D=1 throughout -> stall for 11 cycles, including the start cycle; released when busy_cnt=0.
- Reset mid-multiply: busy_cnt=3, rst=1 for one edge -> busy_cnt=0, md_busy=0, stall=0 next cycle.
- HAZARD_STAT_EN: 7 stall cycles after reset -> stall_cnt=7; preloaded 32'hFFFF_FFFF plus a stall -> stays FFFF_FFFF.
